ifft_16point_36bit: RTL and testbench

16-point radix-2 inverse FFT on packed 36-bit complex samples. It returns the frequency-domain frames produced by the forward 16-point FFT to the time domain, so spectrally processed data can be resynthesised.
The block is iterative. One bank of 8 butterfly units is reused across 4 stage cycles and driven by a start/done level handshake.
It is computed as conj(FFT(conj(X))), with a 1/2 scale per stage, giving an overall 1/16 normalisation.

---
 rtl/ifft_16point_36bit.sv | 175 +++++++++++++++++
 tb/tb_ifft_16point_36bit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_16point_36bit.sv
// Iterative 16-point radix-2 inverse FFT on packed {re,im} Q1.17 samples.
// Computed as conj(FFT(conj(X))); each stage halves, so the result is IDFT/16.
module ifft_16point_36bit #(
    parameter int WIDTH    = 36,
    parameter int N_POINTS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] inputs  [0:N_POINTS-1],
    output logic [WIDTH-1:0] outputs [0:N_POINTS-1],
    output logic             done,
    output logic             busy
);
    localparam int HW = WIDTH / 2;
    localparam int PW = 2 * HW + 1;
    localparam logic signed [HW-1:0] Q_MIN = {1'b1, {(HW-1){1'b0}}};
    localparam logic signed [HW-1:0] Q_MAX = {1'b0, {(HW-1){1'b1}}};

    typedef enum logic [2:0] {
        IDLE, LOAD, STAGE_1, STAGE_2, STAGE_3, STAGE_4, DONE
    } state_t;

    state_t state, state_next;

    logic signed [HW-1:0] dr [0:N_POINTS-1];
    logic signed [HW-1:0] di [0:N_POINTS-1];
    logic signed [HW-1:0] nr [0:N_POINTS-1];
    logic signed [HW-1:0] ni [0:N_POINTS-1];

    function automatic logic [WIDTH-1:0] conj_sat(input logic [WIDTH-1:0] s);
        logic signed [HW-1:0] im;
        im = s[HW-1:0];
        return {s[WIDTH-1:HW], (im == Q_MIN) ? Q_MAX : -im};
    endfunction

    function automatic logic [3:0] bitrev(input logic [3:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

    // Forward-sign twiddles W_16^k = cos - j*sin; unit magnitude saturates to 2^17-1.
    function automatic logic signed [HW-1:0] tw_re(input logic [2:0] k);
        case (k)
            3'd0:    return HW'(131071);
            3'd1:    return HW'(121095);
            3'd2:    return HW'(92682);
            3'd3:    return HW'(50159);
            3'd4:    return HW'(0);
            3'd5:    return HW'(-50159);
            3'd6:    return HW'(-92682);
            default: return HW'(-121095);
        endcase
    endfunction

    function automatic logic signed [HW-1:0] tw_im(input logic [2:0] k);
        case (k)
            3'd0:    return HW'(0);
            3'd1:    return HW'(-50159);
            3'd2:    return HW'(-92682);
            3'd3:    return HW'(-121095);
            3'd4:    return HW'(-131071);
            3'd5:    return HW'(-121095);
            3'd6:    return HW'(-92682);
            default: return HW'(-50159);
        endcase
    endfunction

    // Butterfly b of stage sc+1: top index is b with a 0 inserted at bit sc.
    function automatic logic [3:0] top_idx(input logic [2:0] b, input logic [1:0] sc);
        case (sc)
            2'd0:    return {b, 1'b0};
            2'd1:    return {b[2:1], 1'b0, b[0]};
            2'd2:    return {b[2], 1'b0, b[1:0]};
            default: return {1'b0, b};
        endcase
    endfunction

    function automatic logic [2:0] tw_idx(input logic [2:0] b, input logic [1:0] sc);
        case (sc)
            2'd0:    return 3'd0;
            2'd1:    return {b[0], 2'b00};
            2'd2:    return {b[1:0], 1'b0};
            default: return b;
        endcase
    endfunction

    logic [1:0] stage_sel;
    logic [2:0] b3, k;
    logic [3:0] top, bot;
    logic signed [PW-1:0] wr, wi, br, bim, pr, pim, ar, aim;

    always_comb begin
        stage_sel = 2'd0;
        b3 = '0; k = '0; top = '0; bot = '0;
        wr = '0; wi = '0; br = '0; bim = '0; pr = '0; pim = '0; ar = '0; aim = '0;
        case (state)
            STAGE_1: stage_sel = 2'd1;
            STAGE_2: stage_sel = 2'd2;
            STAGE_3: stage_sel = 2'd3;
            default: stage_sel = 2'd0;
        endcase
        for (int unsigned i = 0; i < N_POINTS; i++) begin
            nr[i] = dr[i];
            ni[i] = di[i];
        end
        for (int unsigned b = 0; b < N_POINTS / 2; b++) begin
            b3  = 3'(b);
            top = top_idx(b3, stage_sel);
            bot = top | (4'd1 << stage_sel);
            k   = tw_idx(b3, stage_sel);
            wr  = PW'(tw_re(k));
            wi  = PW'(tw_im(k));
            br  = PW'(dr[bot]);
            bim = PW'(di[bot]);
            ar  = PW'(dr[top]);
            aim = PW'(di[top]);
            pr  = (br * wr - bim * wi) >>> (HW - 1);
            pim = (br * wi + bim * wr) >>> (HW - 1);
            nr[top] = HW'((ar + pr) >>> 1);
            ni[top] = HW'((aim + pim) >>> 1);
            nr[bot] = HW'((ar - pr) >>> 1);
            ni[bot] = HW'((aim - pim) >>> 1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = STAGE_1;
            STAGE_1: state_next = STAGE_2;
            STAGE_2: state_next = STAGE_3;
            STAGE_3: state_next = STAGE_4;
            STAGE_4: state_next = DONE;
            DONE:    if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
            for (int unsigned i = 0; i < N_POINTS; i++) begin
                dr[i]      <= '0;
                di[i]      <= '0;
                outputs[i] <= '0;
            end
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (start) begin
                    busy <= 1'b1;
                    for (int unsigned i = 0; i < N_POINTS; i++)
                        {dr[i], di[i]} <= conj_sat(inputs[bitrev(4'(i))]);
                end
                LOAD, STAGE_1, STAGE_2, STAGE_3: begin
                    for (int unsigned i = 0; i < N_POINTS; i++) begin
                        dr[i] <= nr[i];
                        di[i] <= ni[i];
                    end
                end
                STAGE_4: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    for (int unsigned i = 0; i < N_POINTS; i++)
                        outputs[i] <= conj_sat({dr[i], di[i]});
                end
                DONE: if (!start) done <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ifft_16point_36bit.sv
// Bench for ifft_16point_36bit: directed table, handshake/reset sequences and
// random round-trip frames checked against a floating-point DFT reference.
module tb_ifft_16point_36bit;
    localparam real PI = 3.14159265358979;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [35:0] inputs  [0:15];
    logic [35:0] outputs [0:15];
    logic        done, busy;

    int errors = 0;
    int checks = 0;

    int  in_re [16];
    int  in_im [16];
    real mdl_re [16];
    real mdl_im [16];
    int  xr [16];
    int  xi [16];

    typedef struct {
        int pattern;
        int out_idx;
        int exp_re;
        int exp_im;
        int tol;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    ifft_16point_36bit #(.WIDTH(36), .N_POINTS(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .inputs  (inputs),
        .outputs (outputs),
        .done    (done),
        .busy    (busy)
    );

    function automatic int out_re(int k);
        logic signed [17:0] v;
        v = outputs[k][35:18];
        return int'(v);
    endfunction

    function automatic int out_im(int k);
        logic signed [17:0] v;
        v = outputs[k][17:0];
        return int'(v);
    endfunction

    function automatic int rnd(real r);
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(0.5 - r);
    endfunction

    function automatic real rabs(real r);
        return (r < 0.0) ? -r : r;
    endfunction

    task automatic check(string name, int act, int exp, int tol);
        checks++;
        if ((act - exp) > tol || (exp - act) > tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    task automatic check_le(string name, real act, real lim);
        checks++;
        if (act > lim) begin
            errors++;
            $display("FAIL %s: max error %0f exceeds %0f", name, act, lim);
        end
    endtask

    task automatic set_pattern(int p);
        for (int k = 0; k < 16; k++) begin
            in_re[k] = 0;
            in_im[k] = 0;
        end
        case (p)
            0: in_re[0] = 131071;
            1: for (int k = 0; k < 16; k++) in_re[k] = 131071;
            default: in_re[1] = 16384;
        endcase
    endtask

    task automatic apply_spectrum();
        for (int k = 0; k < 16; k++)
            inputs[k] = {18'(in_re[k]), 18'(in_im[k])};
    endtask

    // Ideal x[n] = (1/16) * sum_k X[k] e^{+j 2 pi k n / 16}
    task automatic compute_model();
        real sr, si, a;
        for (int n = 0; n < 16; n++) begin
            sr = 0.0;
            si = 0.0;
            for (int k = 0; k < 16; k++) begin
                a  = 2.0 * PI * k * n / 16.0;
                sr = sr + in_re[k] * $cos(a) - in_im[k] * $sin(a);
                si = si + in_re[k] * $sin(a) + in_im[k] * $cos(a);
            end
            mdl_re[n] = sr / 16.0;
            mdl_im[n] = si / 16.0;
        end
    endtask

    function automatic real model_err();
        real m, e;
        m = 0.0;
        for (int n = 0; n < 16; n++) begin
            e = rabs(out_re(n) - mdl_re[n]);
            if (e > m) m = e;
            e = rabs(out_im(n) - mdl_im[n]);
            if (e > m) m = e;
        end
        return m;
    endfunction

    task automatic run_frame(input bit drop_early, output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        bcnt = int'(busy);
        if (drop_early) start = 1'b0;
        lat = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (busy) bcnt++;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic end_frame(string name);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check(name, int'(done), 0, 0);
    endtask

    function automatic int nonzero_outputs();
        int c;
        c = 0;
        for (int k = 0; k < 16; k++) if (outputs[k] != 36'd0) c++;
        return c;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bcnt, rt;
        real fr, fi, a;

        tbl[0] = '{0, 0,  8191,     0, 0};
        tbl[1] = '{0, 9,  8191,     0, 0};
        tbl[2] = '{0, 15, 8191,     0, 0};
        tbl[3] = '{1, 0,  131068,   0, 4};
        tbl[4] = '{1, 5,  0,        0, 4};
        tbl[5] = '{2, 4,  0,     1024, 4};
        tbl[6] = '{2, 12, 0,    -1024, 4};
        tbl[7] = '{2, 0,  1024,     0, 4};

        for (int k = 0; k < 16; k++) inputs[k] = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_done", int'(done), 0, 0);
        check("reset_busy", int'(busy), 0, 0);
        check("reset_outputs_nonzero", nonzero_outputs(), 0, 0);
        @(negedge clk);
        reset = 1'b1;

        // sub-cycle start pulse between edges must be ignored
        set_pattern(0);
        apply_spectrum();
        @(negedge clk);
        #1 start = 1'b1;
        #2 start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("glitch_busy", int'(busy), 0, 0);
        end

        for (int i = 0; i < 8; i++) begin
            set_pattern(tbl[i].pattern);
            apply_spectrum();
            compute_model();
            run_frame(1'b0, lat, bcnt);
            check($sformatf("row%0d_latency", i), lat, 5, 0);
            check($sformatf("row%0d_busy_cycles", i), bcnt, 5, 0);
            check($sformatf("row%0d_re", i), out_re(tbl[i].out_idx), tbl[i].exp_re, tbl[i].tol);
            check($sformatf("row%0d_im", i), out_im(tbl[i].out_idx), tbl[i].exp_im, tbl[i].tol);
            check_le($sformatf("row%0d_model", i), model_err(), 4.0);
            end_frame($sformatf("row%0d_done_drop", i));
        end

        // reset asserted while in STAGE_2
        set_pattern(0);
        apply_spectrum();
        @(negedge clk);
        start = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_outputs_nonzero", nonzero_outputs(), 0, 0);
        check("abort_done", int'(done), 0, 0);
        check("abort_busy", int'(busy), 0, 0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        set_pattern(2);
        apply_spectrum();
        compute_model();
        run_frame(1'b0, lat, bcnt);
        check("after_abort_latency", lat, 5, 0);
        check_le("after_abort_model", model_err(), 4.0);
        end_frame("after_abort_done_drop");

        // hold start past done while inputs change
        set_pattern(0);
        apply_spectrum();
        run_frame(1'b0, lat, bcnt);
        check("hold_latency", lat, 5, 0);
        set_pattern(1);
        apply_spectrum();
        repeat (3) begin
            @(posedge clk);
            #1;
            check("hold_done", int'(done), 1, 0);
        end
        for (int k = 0; k < 16; k++) begin
            check($sformatf("hold_re%0d", k), out_re(k), 8191, 0);
            check($sformatf("hold_im%0d", k), out_im(k), 0, 0);
        end
        end_frame("hold_done_drop");
        check("idle_hold_re", out_re(3), 8191, 0);
        compute_model();
        run_frame(1'b0, lat, bcnt);
        check("restart_latency", lat, 5, 0);
        check_le("restart_model", model_err(), 4.0);
        end_frame("restart_done_drop");

        // start dropped mid-computation: one-cycle done
        set_pattern(2);
        apply_spectrum();
        compute_model();
        run_frame(1'b1, lat, bcnt);
        check("early_drop_latency", lat, 5, 0);
        check_le("early_drop_model", model_err(), 4.0);
        @(posedge clk);
        #1;
        check("early_drop_done_pulse", int'(done), 0, 0);

        // random round trips: ideal forward DFT then the DUT
        for (int f = 0; f < 100; f++) begin
            for (int n = 0; n < 16; n++) begin
                xr[n] = int'($urandom_range(8190)) - 4095;
                xi[n] = int'($urandom_range(8190)) - 4095;
            end
            for (int k = 0; k < 16; k++) begin
                fr = 0.0;
                fi = 0.0;
                for (int n = 0; n < 16; n++) begin
                    a  = 2.0 * PI * k * n / 16.0;
                    fr = fr + xr[n] * $cos(a) + xi[n] * $sin(a);
                    fi = fi + xi[n] * $cos(a) - xr[n] * $sin(a);
                end
                in_re[k] = rnd(fr);
                in_im[k] = rnd(fi);
            end
            apply_spectrum();
            compute_model();
            run_frame(1'b0, lat, bcnt);
            check($sformatf("rand%0d_latency", f), lat, 5, 0);
            check_le($sformatf("rand%0d_model", f), model_err(), 4.0);
            rt = 0;
            for (int n = 0; n < 16; n++) begin
                if (out_re(n) - xr[n] > rt) rt = out_re(n) - xr[n];
                if (xr[n] - out_re(n) > rt) rt = xr[n] - out_re(n);
                if (out_im(n) - xi[n] > rt) rt = out_im(n) - xi[n];
                if (xi[n] - out_im(n) > rt) rt = xi[n] - out_im(n);
            end
            check($sformatf("rand%0d_roundtrip_maxerr", f), rt, 0, 8);
            end_frame($sformatf("rand%0d_done_drop", f));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
